fetch_queue_stage: RTL and testbench

Parametrised fetch stage that decouples PC generation from decode with an instruction queue and an in-order, variable-latency valid/ready instruction-memory port. It keeps up to MAX_OUTSTANDING requests in flight, buffers returned instructions with their PCs, and presents them to decode under the hazard unit's stall control. A redirect discards queued and in-flight fetches cleanly. It sits between the instruction memory and the IF/ID boundary, replacing the fixed single-cycle fetch path.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_queue_stage.sv | 128 ++++++++++++
 tb/tb_fetch_queue_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the queued fetch stage.
package fetch_pkg;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
   localparam logic [6:0]  OPC_JAL  = 7'b1101111;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
      logic        predicted;
   } q_entry_t;

   function automatic logic [31:0] j_imm(input logic [31:0] insn);
      return {{12{insn[31]}}, insn[19:12], insn[20],
              insn[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; push and pop may coincide at any level.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [2**AW];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_queue_stage.sv
// Queued fetch with in-order imem port and redirect drop counting.
// FETCH_JAL_PREDECODE_EN enables JAL predecode redirect in fetch.
module fetch_queue_stage
   import fetch_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int              QUEUE_DEPTH     = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_en,
   input  logic            jump_en,
   input  logic [XLEN-1:0] pc_jump_addr,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   output logic [31:0]     instruction,
   output logic [XLEN-1:0] pc,
   output logic            inst_predicted
);

   localparam int QCW = $clog2(QUEUE_DEPTH + 1);
   localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

   logic            running;
   logic [XLEN-1:0] fetch_pc;
   logic [OCW-1:0]  drop_cnt;
   logic [OCW-1:0]  outstanding;
   logic [OCW-1:0]  out_next;
   logic [QCW-1:0]  q_count;
   logic            q_empty;
   logic            q_full;
   logic            tag_empty;
   logic            tag_full;
   logic [XLEN-1:0] tag;
   q_entry_t        q_in;
   q_entry_t        q_head;
   logic            accept;
   logic            rsp_take;
   logic            keep;
   logic            jal_hit;
   logic            q_pop;

   // Queue space is reserved at issue so responses never overflow it.
   assign imem_req_valid = running && !tag_full && !q_full &&
      (int'(q_count) + int'(outstanding) < QUEUE_DEPTH);
   assign imem_req_addr  = fetch_pc;

   assign accept   = imem_req_valid && imem_req_ready;
   assign rsp_take = imem_rsp_valid && !tag_empty;
   assign keep     = rsp_take && (drop_cnt == '0);
   assign out_next = outstanding + OCW'(accept) - OCW'(rsp_take);
   assign q_pop    = !q_empty && pc_en;

`ifdef FETCH_JAL_PREDECODE_EN
   assign jal_hit = keep && (imem_rsp_data[6:0] == OPC_JAL);
`else
   assign jal_hit = 1'b0;
`endif

   assign q_in = '{pc: 32'(tag),
                   instruction: imem_rsp_data,
                   predicted: jal_hit};

   always_ff @(posedge clk) begin
      if (!rst) begin
         running  <= 1'b0;
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         running <= 1'b1;
         if (jump_en) begin
            fetch_pc <= pc_jump_addr & ~XLEN'(3);
            drop_cnt <= out_next;
         end else if (jal_hit) begin
            fetch_pc <= tag + XLEN'($signed(j_imm(imem_rsp_data)));
            drop_cnt <= out_next;
         end else begin
            if (accept) fetch_pc <= fetch_pc + XLEN'(4);
            if (rsp_take && drop_cnt != '0)
               drop_cnt <= drop_cnt - OCW'(1);
         end
      end
   end

   fetch_fifo #(
      .WIDTH($bits(q_entry_t)),
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clk      (clk),
      .rst      (rst),
      .clear    (jump_en),
      .push     (keep),
      .push_data(q_in),
      .pop      (q_pop),
      .pop_data (q_head),
      .empty    (q_empty),
      .full     (q_full),
      .count    (q_count)
   );

   fetch_fifo #(
      .WIDTH(XLEN),
      .DEPTH(MAX_OUTSTANDING)
   ) u_tags (
      .clk      (clk),
      .rst      (rst),
      .clear    (1'b0),
      .push     (accept),
      .push_data(fetch_pc),
      .pop      (rsp_take),
      .pop_data (tag),
      .empty    (tag_empty),
      .full     (tag_full),
      .count    (outstanding)
   );

   assign inst_valid     = !q_empty;
   assign instruction    = inst_valid ? q_head.instruction : NOP_INSN;
   assign pc             = inst_valid ? XLEN'(q_head.pc) : '0;
   assign inst_predicted = inst_valid && q_head.predicted;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage with a latency-configurable imem.
module tb_fetch_queue_stage;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_en = 1'b0;
   logic        jump_en = 1'b0;
   logic [31:0] pc_jump_addr = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        inst_predicted;

   int n_checks = 0;
   int n_fails = 0;
   int cyc = 0;
   int lat = 1;
   bit jal_mode = 1'b0;
   int pops = 0;
   int accepts = 0;
   int first_acc = -1;
   int first_val = -1;
   logic [31:0] first_acc_addr = '0;
   logic [31:0] last_acc_addr = '0;
   logic [31:0] last_pc = '1;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t    pend[$];
   q_entry_t exp_q[$];

   always #5 clk = ~clk;

   fetch_queue_stage dut (
      .clk           (clk),
      .rst           (rst),
      .pc_en         (pc_en),
      .jump_en       (jump_en),
      .pc_jump_addr  (pc_jump_addr),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .inst_valid    (inst_valid),
      .instruction   (instruction),
      .pc            (pc),
      .inst_predicted(inst_predicted)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      if (jal_mode && a == 32'h8) return 32'h0100_006F;
      return {a[24:0], 7'h13};
   endfunction

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_one(input logic [31:0] a, input logic p);
      q_entry_t e;
      e.pc = a;
      e.instruction = inst_of(a);
      e.predicted = p;
      exp_q.push_back(e);
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) push_one(start + 32'(4 * i), 1'b0);
   endtask

   task automatic wait_pc(input logic [31:0] target);
      int k = 0;
      while (last_pc !== target && k < 200) begin
         tick(1);
         k++;
      end
      check("reach_pc", last_pc, target);
   endtask

   task automatic first_req(input logic [31:0] target);
      int a0 = accepts;
      int k = 0;
      while (accepts == a0 && k < 50) begin
         tick(1);
         k++;
      end
      check("redirect_req_addr", last_acc_addr, target);
   endtask

   // imem model: in-order, response lat cycles after acceptance
   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         pend.delete();
      end else begin
         if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
         if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_req_addr, cyc + lat - 1});
            accepts++;
            last_acc_addr = imem_req_addr;
            if (first_acc < 0) begin
               first_acc = cyc - 1;
               first_acc_addr = imem_req_addr;
            end
         end
      end
   end

   always @(negedge clk) begin
      imem_rsp_valid = 1'b0;
      if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = inst_of(pend[0].addr);
      end
   end

   always @(negedge clk) begin : monitor
      q_entry_t e;
      if (rst && inst_valid && pc_en) begin
         pops++;
         if (first_val < 0) first_val = cyc;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_entry: pc %h with none expected", pc);
         end else begin
            e = exp_q.pop_front();
            check("entry_pc", pc, e.pc);
            check("entry_insn", instruction, e.instruction);
            check("entry_pred", 32'(inst_predicted), 32'(e.predicted));
         end
         last_pc = pc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int p0;
      int a0;
      int k;
      logic [31:0] hold;

      imem_req_ready = 1'b1;
      tick(3);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_instruction", instruction, 32'h0000_0013);
      check("rst_pc", pc, 32'd0);
      check("rst_predicted", 32'(inst_predicted), 32'd0);

      push_seq(32'h0, 256);
      pc_en = 1'b1;
      rst = 1'b1;
      tick(30);
      check("first_req_addr", first_acc_addr, 32'h0);
      check("first_latency", 32'(first_val - first_acc), 32'd2);

      p0 = pops;
      a0 = accepts;
      tick(10);
      check("throughput_pops", 32'(pops - p0), 32'd10);
      check("throughput_reqs", 32'(accepts - a0), 32'd10);

      pc_en = 1'b0;
      a0 = accepts;
      tick(10);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_inst_valid", 32'(inst_valid), 32'd1);
      check("stall_accepts", 32'(accepts - a0), 32'd2);
      pc_en = 1'b1;
      tick(20);

      imem_req_ready = 1'b0;
      hold = imem_req_addr;
      a0 = accepts;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("hold_addr", imem_req_addr, hold);
         check("hold_valid", 32'(imem_req_valid), 32'd1);
      end
      check("hold_accepts", 32'(accepts - a0), 32'd0);
      imem_req_ready = 1'b1;
      tick(1);
      check("hold_release_addr", last_acc_addr, hold);
      tick(20);

      lat = 3;
      tick(10);
      k = 0;
      while (pend.size() != 2 && k < 20) begin
         tick(1);
         k++;
      end
      check("inflight_before_jump", 32'(pend.size()), 32'd2);
      pc_jump_addr = 32'h103;
      jump_en = 1'b1;
      tick(1);
      jump_en = 1'b0;
      check("jump1_inst_valid", 32'(inst_valid), 32'd0);
      check("jump1_drop_cnt", 32'(dut.drop_cnt), 32'(pend.size()));
      exp_q.delete();
      push_seq(32'h100, 256);
      first_req(32'h100);
      wait_pc(32'h120);

      lat = 1;
      tick(20);
      pc_jump_addr = 32'h200;
      jump_en = 1'b1;
      @(negedge clk);
      #1;
      check("jump2_rsp_same", 32'(imem_rsp_valid), 32'd1);
      check("jump2_pop_same", 32'(inst_valid), 32'd1);
      @(posedge clk);
      #1;
      jump_en = 1'b0;
      check("jump2_inst_valid", 32'(inst_valid), 32'd0);
      check("jump2_outstanding", 32'(pend.size()), 32'd1);
      check("jump2_drop_cnt", 32'(dut.drop_cnt), 32'd1);
      check("jump2_req_valid", 32'(imem_req_valid), 32'd1);
      check("jump2_req_addr", imem_req_addr, 32'h200);
      exp_q.delete();
      push_seq(32'h200, 256);
      wait_pc(32'h240);

      jal_mode = 1'b1;
      pc_jump_addr = 32'h0;
      jump_en = 1'b1;
      tick(1);
      jump_en = 1'b0;
      exp_q.delete();
      push_one(32'h0, 1'b0);
      push_one(32'h4, 1'b0);
`ifdef FETCH_JAL_PREDECODE_EN
      push_one(32'h8, 1'b1);
      push_seq(32'h18, 200);
`else
      push_one(32'h8, 1'b0);
      push_seq(32'hC, 200);
`endif
      wait_pc(32'h40);

      pc_en = 1'b0;
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
